slot_arbiter_rr: RTL and testbench
==================================

// Module: slot_arbiter_rr
// PURPOSE
//  Round-robin time-slot arbiter that shares one downstream resource (e.g. a shared modulo
//  counter/timer path) between NUM_REQ requesters. An internal modulo slot counter bounds each
//  grant to SLOT_CYCLES enabled cycles. Sits between requester blocks and the shared datapath.
// PARAMETERS
//  NUM_REQ      4                     number of requesters (>=2)
//  SLOT_CYCLES  8                     max enabled cycles per grant (>=2)
//  SLOT_BITS    CeilLog2(SLOT_CYCLES) slot counter width (3 at default)
//  IDX_BITS     CeilLog2(NUM_REQ)     grant index width (2 at default)
// PORTS
//  clk          in   1          single clock, rising edge
//  reset        in   1          asynchronous, active-high reset
//  enable       in   1          advance arbiter/slot counter when 1; freeze all state when 0
//  request      in   NUM_REQ    level request per requester, bit i = requester i
//  grant        out  NUM_REQ    registered one-hot grant; all-zero when idle
//  grant_valid  out  1          1 when any grant bit is set
//  grant_index  out  IDX_BITS   binary index of granted requester; 0 when idle
//  slot_count   out  SLOT_BITS  cycles elapsed in current slot, 0..SLOT_CYCLES-1
//  slot_end     out  1          combinational: grant_valid && slot_count==SLOT_CYCLES-1
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  - Reset: grant=0, grant_valid=0, grant_index=0, slot_count=0, state=IDLE, last_ptr=NUM_REQ-1.
//  - FSM states: IDLE, BUSY. All state updates require enable=1; enable=0 holds everything.
//  - Round-robin pick: first set bit of request searching last_ptr+1, +2, ... wrapping modulo
//    NUM_REQ. last_ptr updates to the picked index when a grant is issued.
//  - IDLE: if request!=0 -> grant picked requester next cycle (1-cycle latency), slot_count=0,
//    go BUSY. Else stay IDLE.
//  - BUSY, each enabled cycle with owner still requesting and slot_count<SLOT_CYCLES-1:
//    slot_count+1, grant held.
//  - BUSY, owner drops request (early release): next cycle re-pick among request;
//    if none -> IDLE with grant=0. slot_count resets to 0 in both cases.
//  - BUSY, slot_end=1: next cycle re-pick starting after owner (back-to-back, no idle gap).
//    If owner is the only requester it is re-granted for a fresh slot; if no requests -> IDLE.
//  - Owner drop and slot_end in the same cycle: treated as early release (owner not eligible).
//  - slot_count wraps SLOT_CYCLES-1 -> 0 only on slot handover; never exceeds SLOT_CYCLES-1.
//  - grant is always one-hot or zero; grant_index always matches grant.
//  - Requests from non-owners never affect the current slot before slot_end/release.
//  - reset asserted mid-slot: immediate return to reset values, no partial grant held.
// CONFIGURATION
//  Macro SLOT_ARB_LOCK_EN:
//  - Defined: adds input port `lock` (1 bit). When lock=1 during a slot_end cycle and the owner
//    is still requesting, the owner is re-granted (slot_count->0) regardless of other requests;
//    last_ptr unchanged. lock has no effect on early release or in IDLE.
//  - Not defined: no lock port; slot_end always hands over per round-robin rule above.
// TESTING
//  1 Reset: reset=1 mid-operation -> grant=0, grant_valid=0, slot_count=0 asynchronously.
//  2 Single req: request=4'b0100 held -> grant=4'b0100 one cycle later, slot_count 0..7,
//    slot_end at count 7, re-granted to 0100 with slot_count=0.
//  3 Rotation: request=4'b1111 held -> grant sequence 0001,0010,0100,1000,0001, each 8 cycles,
//    no idle cycle between grants.
//  4 Early release: owner 0001 drops request at slot_count=3, request=4'b1000 -> grant=1000 next
//    cycle, slot_count=0; with request=0 -> grant=0, IDLE.
//  5 Enable freeze: enable=0 for 5 cycles at slot_count=2 -> grant and slot_count unchanged;
//    resumes at 3 after enable=1.
//  6 SLOT_ARB_LOCK_EN: request=4'b0011, owner 0001, lock=1 at slot_end -> grant stays 0001,
//    slot_count=0; lock=0 at next slot_end -> grant=0010.

Source files
------------

// File: rtl/slot_arbiter_rr.sv
// Round-robin time-slot arbiter: each grant lasts at most SLOT_CYCLES enabled cycles.
// Optional macro SLOT_ARB_LOCK_EN adds a `lock` input that lets the owner keep the resource at slot end.
module slot_arbiter_rr #(
    parameter int NUM_REQ     = 4,
    parameter int SLOT_CYCLES = 8,
    parameter int SLOT_BITS   = $clog2(SLOT_CYCLES),
    parameter int IDX_BITS    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_REQ-1:0]   request,
`ifdef SLOT_ARB_LOCK_EN
    input  logic                 lock,
`endif
    output logic [NUM_REQ-1:0]   grant,
    output logic                 grant_valid,
    output logic [IDX_BITS-1:0]  grant_index,
    output logic [SLOT_BITS-1:0] slot_count,
    output logic                 slot_end
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t               state_reg, state_next;
    logic [NUM_REQ-1:0]   grant_reg, grant_next;
    logic [IDX_BITS-1:0]  index_reg, index_next;
    logic [IDX_BITS-1:0]  last_ptr_reg, last_ptr_next;
    logic [SLOT_BITS-1:0] slot_reg, slot_next;

    logic [IDX_BITS-1:0]  cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0]   cand_hit;
    logic                 pick_valid;
    logic [IDX_BITS-1:0]  pick_idx;
    logic                 owner_req;
    logic                 slot_last;
    logic                 lock_hold;

`ifdef SLOT_ARB_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    // Candidate gi is the requester gi+1 positions after the last winner.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_idx[gi] = IDX_BITS'((int'(last_ptr_reg) + gi + 1) % NUM_REQ);
            assign cand_hit[gi] = request[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx[k];
            end
        end
    end

    assign owner_req = request[index_reg];
    assign slot_last = (slot_reg == SLOT_BITS'(SLOT_CYCLES - 1));

    always_comb begin
        state_next    = state_reg;
        index_next    = index_reg;
        last_ptr_next = last_ptr_reg;
        slot_next     = slot_reg;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next    = BUSY;
                    index_next    = pick_idx;
                    last_ptr_next = pick_idx;
                    slot_next     = '0;
                end
            end
            BUSY: begin
                if (!owner_req) begin
                    // Early release wins over slot end; owner is not eligible.
                    slot_next = '0;
                    if (pick_valid) begin
                        index_next    = pick_idx;
                        last_ptr_next = pick_idx;
                    end else begin
                        state_next = IDLE;
                        index_next = '0;
                    end
                end else if (slot_last) begin
                    slot_next = '0;
                    if (!lock_hold) begin
                        // Owner still requests, so the search always finds someone.
                        index_next    = pick_idx;
                        last_ptr_next = pick_idx;
                    end
                end else begin
                    slot_next = slot_reg + SLOT_BITS'(1);
                end
            end
            default: begin
                state_next = IDLE;
                index_next = '0;
                slot_next  = '0;
            end
        endcase
    end

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign grant_next[gi] = (state_next == BUSY) && (index_next == IDX_BITS'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            index_reg    <= '0;
            last_ptr_reg <= IDX_BITS'(NUM_REQ - 1);
            slot_reg     <= '0;
        end else if (enable) begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            index_reg    <= index_next;
            last_ptr_reg <= last_ptr_next;
            slot_reg     <= slot_next;
        end
    end

    assign grant       = grant_reg;
    assign grant_valid = |grant_reg;
    assign grant_index = index_reg;
    assign slot_count  = slot_reg;
    assign slot_end    = grant_valid && slot_last;

endmodule

// File: tb/tb_slot_arbiter_rr.sv
// Directed bench for slot_arbiter_rr at default parameters (4 requesters, 8-cycle slots).
// Define SLOT_ARB_LOCK_EN for both files to exercise the lock path as well.
module tb_slot_arbiter_rr;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] request;
`ifdef SLOT_ARB_LOCK_EN
    logic       lock;
`endif
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_index;
    logic [2:0] slot_count;
    logic       slot_end;

    int n_checks = 0;
    int n_fail   = 0;

    slot_arbiter_rr #(.NUM_REQ(4), .SLOT_CYCLES(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .request     (request),
`ifdef SLOT_ARB_LOCK_EN
        .lock        (lock),
`endif
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_index (grant_index),
        .slot_count  (slot_count),
        .slot_end    (slot_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h at %0t", tag, got, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_owner(input string tag, input int idx, input int slot);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        check_value({tag, ".grant"}, 32'(grant), 32'(oh));
        check_value({tag, ".index"}, 32'(grant_index), 32'(idx));
        check_value({tag, ".slot"}, 32'(slot_count), 32'(slot));
        check_value({tag, ".slot_end"}, 32'(slot_end), 32'(slot == 7));
    endtask

    task automatic check_idle(input string tag);
        check_value({tag, ".grant"}, 32'(grant), 32'd0);
        check_value({tag, ".valid"}, 32'(grant_valid), 32'd0);
        check_value({tag, ".index"}, 32'(grant_index), 32'd0);
        check_value({tag, ".slot"}, 32'(slot_count), 32'd0);
    endtask

    int rot_seq [5] = '{3, 0, 1, 2, 3};

    initial begin
        reset   = 1'b1;
        enable  = 1'b1;
        request = 4'b0000;
`ifdef SLOT_ARB_LOCK_EN
        lock    = 1'b0;
`endif
        tick();
        tick();
        check_idle("reset");
        check_value("reset.slot_end", 32'(slot_end), 32'd0);
        reset = 1'b0;
        tick();
        check_idle("idle_no_req");

        // Single requester: full slot then re-grant to itself.
        request = 4'b0100;
        tick();
        for (int c = 0; c < 8; c++) begin
            check_owner("single", 2, c);
            tick();
        end
        check_owner("single_regrant", 2, 0);

        // Drop to idle, then rotation starting after last winner (2).
        request = 4'b0000;
        tick();
        check_idle("release_idle");
        request = 4'b1111;
        tick();
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 8; c++) begin
                check_owner($sformatf("rot%0d", s), rot_seq[s], c);
                tick();
            end
        end
        check_owner("rot_next", 0, 0);

        // Early release by owner 0 at slot 3.
        tick();
        tick();
        tick();
        check_owner("pre_release", 0, 3);
        request = 4'b1000;
        tick();
        check_owner("early_release", 3, 0);
        request = 4'b0000;
        tick();
        check_idle("release_to_idle");
        tick();
        check_idle("stay_idle");

        // Enable freeze at slot 2; request changes are ignored while frozen.
        request = 4'b0010;
        tick();
        tick();
        tick();
        check_owner("pre_freeze", 1, 2);
        enable  = 1'b0;
        request = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_owner($sformatf("freeze%0d", c), 1, 2);
        end
        request = 4'b0010;
        enable  = 1'b1;
        tick();
        check_owner("resume", 1, 3);

        // Owner drops exactly at slot end: early release path.
        for (int c = 4; c < 8; c++) tick();
        check_owner("at_slot_end", 1, 7);
        request = 4'b0001;
        tick();
        check_owner("drop_at_end", 0, 0);

        // Asynchronous reset mid-slot.
        tick();
        tick();
        check_owner("pre_reset", 0, 2);
        #2;
        reset = 1'b1;
        #1;
        check_idle("async_reset");
        #1;
        reset   = 1'b0;
        request = 4'b1111;
        tick();
        check_owner("post_reset_ptr", 0, 0);

`ifdef SLOT_ARB_LOCK_EN
        request = 4'b0011;
        for (int c = 1; c < 8; c++) tick();
        check_owner("lock_pre", 0, 7);
        lock = 1'b1;
        tick();
        check_owner("lock_hold", 0, 0);
        lock = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        check_owner("lock_release", 1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
